// File: rtl/control_types_pkg.sv
// Shared control encodings between the ID/EX register and the EX-stage ALU.
// ALU_NOP is deliberately the all-zero code so a cleared register is a bubble.
package control_types_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SL  = 4'd3,
    ALU_LT  = 4'd4,
    ALU_LTU = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_OR  = 4'd9,
    ALU_AND = 4'd10,
    ALU_LUI = 4'd11
  } alu_op_t;

endpackage

// File: rtl/id_ex_decode_reg.sv
// RV32I ID-stage decoder feeding the ID/EX pipeline register (stall hold, flush bubble).
// Optional bubble counter output bubble_cnt_o when ID_EX_PERF_CNT_EN is defined.
module id_ex_decode_reg
  import control_types_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
`ifdef ID_EX_PERF_CNT_EN
  parameter int unsigned PERF_CNT_W = 32,
`endif
  parameter int unsigned REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              instr_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output alu_op_t           ex_alu_op_o,
  output logic              ex_src_a_pc_o,
  output logic              ex_src_b_imm_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_reg_write_o,
  output logic [XLEN-1:0]   ex_pc_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] bubble_cnt_o,
`endif
  output logic              ex_illegal_o
);

  typedef struct packed {
    logic              valid;
    alu_op_t           op;
    logic              a_pc;
    logic              b_imm;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [XLEN-1:0]   pc;
    logic              ill;
  } id_ex_t;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        f7_zero, f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                   1'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  // funct3 -> op for the non-alternate OP/OP-IMM encodings
  function automatic alu_op_t f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SL;
      3'b010:  return ALU_LT;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  id_ex_t dec;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rs1   = instr_i[19:15];
    dec.rs2   = instr_i[24:20];
    dec.rd    = instr_i[11:7];
    dec.pc    = pc_i;
    case (opcode)
      OpcOp: begin
        dec.we = 1'b1;
        if (f7_zero) dec.op = f3_op(funct3);
        else if (f7_alt && funct3 == 3'b000) dec.op = ALU_SUB;
        else if (f7_alt && funct3 == 3'b101) dec.op = ALU_SRA;
        else dec.ill = 1'b1;
      end
      OpcOpImm: begin
        dec.we    = 1'b1;
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
        dec.op    = f3_op(funct3);
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          dec.ill = !f7_zero;
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          if (f7_alt) dec.op = ALU_SRA;
          dec.ill = !(f7_zero || f7_alt);
        end
      end
      OpcLui: begin
        dec.op    = ALU_LUI;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
        dec.we    = 1'b1;
      end
      OpcAuipc, OpcJal: begin
        dec.op    = ALU_ADD;
        dec.a_pc  = 1'b1;
        dec.b_imm = 1'b1;
        dec.imm   = (opcode == OpcJal) ? imm_j : imm_u;
        dec.we    = 1'b1;
      end
      OpcLoad, OpcJalr: begin
        dec.op    = ALU_ADD;
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
        dec.we    = 1'b1;
        if (opcode == OpcJalr) dec.ill = (funct3 != 3'b000);
        else dec.ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OpcStore: begin
        dec.op    = ALU_ADD;
        dec.b_imm = 1'b1;
        dec.imm   = imm_s;
        dec.ill   = funct3[2] || (funct3 == 3'b011);
      end
      OpcBranch: begin
        dec.imm = imm_b;
        case (funct3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b10:   dec.op = ALU_LT;
          2'b11:   dec.op = ALU_LTU;
          default: dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal encodings keep register indices and PC but drop every control effect.
    if (dec.ill) begin
      dec.op    = ALU_NOP;
      dec.a_pc  = 1'b0;
      dec.b_imm = 1'b0;
      dec.imm   = '0;
      dec.we    = 1'b0;
    end
    if (dec.rd == '0) dec.we = 1'b0;
  end

  id_ex_t id_ex_d, id_ex_q;

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_i) id_ex_d = '0;
    else if (!stall_i) id_ex_d = instr_valid_i ? dec : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) id_ex_q <= '0;
    else id_ex_q <= id_ex_d;
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i || (!stall_i && !instr_valid_i)) bubble_cnt_d = bubble_cnt_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

  assign ex_valid_o     = id_ex_q.valid;
  assign ex_alu_op_o    = id_ex_q.op;
  assign ex_src_a_pc_o  = id_ex_q.a_pc;
  assign ex_src_b_imm_o = id_ex_q.b_imm;
  assign ex_imm_o       = id_ex_q.imm;
  assign ex_rs1_o       = id_ex_q.rs1;
  assign ex_rs2_o       = id_ex_q.rs2;
  assign ex_rd_o        = id_ex_q.rd;
  assign ex_reg_write_o = id_ex_q.we;
  assign ex_pc_o        = id_ex_q.pc;
  assign ex_illegal_o   = id_ex_q.ill;

endmodule

// File: tb/tb_id_ex_decode_reg.sv
// Randomized bench for id_ex_decode_reg against an ISA-level reference model,
// plus directed literal checks; covers bubble_cnt_o when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_decode_reg;
  import control_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_valid_o, ex_src_a_pc_o, ex_src_b_imm_o, ex_reg_write_o, ex_illegal_o;
  alu_op_t     ex_alu_op_o;
  logic [31:0] ex_imm_o, ex_pc_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o;
  logic [31:0] cnt_model;
  logic [31:0] cnt_snap;
`endif

  always #5 clk = ~clk;

  id_ex_decode_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_i        (instr_i),
    .pc_i           (pc_i),
    .instr_valid_i  (instr_valid_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .ex_valid_o     (ex_valid_o),
    .ex_alu_op_o    (ex_alu_op_o),
    .ex_src_a_pc_o  (ex_src_a_pc_o),
    .ex_src_b_imm_o (ex_src_b_imm_o),
    .ex_imm_o       (ex_imm_o),
    .ex_rs1_o       (ex_rs1_o),
    .ex_rs2_o       (ex_rs2_o),
    .ex_rd_o        (ex_rd_o),
    .ex_reg_write_o (ex_reg_write_o),
    .ex_pc_o        (ex_pc_o),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt_o   (bubble_cnt_o),
`endif
    .ex_illegal_o   (ex_illegal_o)
  );

  typedef struct packed {
    logic        valid;
    alu_op_t     op;
    logic        a_pc;
    logic        b_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  exp_t exp_q;

  alu_op_t    base_tbl [8] = '{ALU_ADD, ALU_SL, ALU_LT, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  alu_op_t    br_tbl   [8] = '{ALU_SUB, ALU_SUB, ALU_NOP, ALU_NOP, ALU_LT, ALU_LT, ALU_LTU, ALU_LTU};
  logic [7:0] load_ok  = 8'b0011_0111;
  logic [7:0] store_ok = 8'b0000_0111;
  logic [7:0] br_ok    = 8'b1111_0011;
  logic [6:0] opc_tbl [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA tables.
  function automatic exp_t decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, wr;
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    e.valid = 1'b1;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    e.pc  = pc;
    ok = 1'b1;
    wr = 1'b1;
    case (i[6:0])
      7'h33: begin
        e.op = base_tbl[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
        else ok = (f7 == 7'h00);
      end
      7'h13: begin
        e.op = base_tbl[f3];
        e.b_imm = 1'b1;
        e.imm = $signed(i[31:20]);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = 32'(i[24:20]);
          if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        end
      end
      7'h37: begin e.op = ALU_LUI; e.b_imm = 1'b1; e.imm = {i[31:12], 12'h000}; end
      7'h17: begin e.op = ALU_ADD; e.a_pc = 1'b1; e.b_imm = 1'b1; e.imm = {i[31:12], 12'h000}; end
      7'h03: begin e.op = ALU_ADD; e.b_imm = 1'b1; e.imm = $signed(i[31:20]); ok = load_ok[f3]; end
      7'h23: begin
        e.op = ALU_ADD; e.b_imm = 1'b1; e.imm = $signed({i[31:25], i[11:7]});
        ok = store_ok[f3]; wr = 1'b0;
      end
      7'h63: begin
        e.op = br_tbl[f3]; e.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        ok = br_ok[f3]; wr = 1'b0;
      end
      7'h6F: begin
        e.op = ALU_ADD; e.a_pc = 1'b1; e.b_imm = 1'b1;
        e.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      7'h67: begin e.op = ALU_ADD; e.b_imm = 1'b1; e.imm = $signed(i[31:20]); ok = (f3 == 3'd0); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ill = 1'b1; e.op = ALU_NOP; e.a_pc = 1'b0; e.b_imm = 1'b0; e.imm = '0; wr = 1'b0;
    end
    e.we = wr && (e.rd != 5'd0);
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) exp_q <= '0;
    else if (flush_i) exp_q <= '0;
    else if (!stall_i) exp_q <= instr_valid_i ? decode(instr_i, pc_i) : '0;
  end

`ifdef ID_EX_PERF_CNT_EN
  always @(posedge clk) begin
    if (!rst_n) cnt_model <= '0;
    else if (flush_i || (!stall_i && !instr_valid_i)) cnt_model <= cnt_model + 32'd1;
  end
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(ex_valid_o), 32'(exp_q.valid));
      check("alu_op", 32'(ex_alu_op_o), 32'(exp_q.op));
      check("src_a_pc", 32'(ex_src_a_pc_o), 32'(exp_q.a_pc));
      check("src_b_imm", 32'(ex_src_b_imm_o), 32'(exp_q.b_imm));
      check("imm", ex_imm_o, exp_q.imm);
      check("rs1", 32'(ex_rs1_o), 32'(exp_q.rs1));
      check("rs2", 32'(ex_rs2_o), 32'(exp_q.rs2));
      check("rd", 32'(ex_rd_o), 32'(exp_q.rd));
      check("reg_write", 32'(ex_reg_write_o), 32'(exp_q.we));
      check("pc", ex_pc_o, exp_q.pc);
      check("illegal", 32'(ex_illegal_o), 32'(exp_q.ill));
`ifdef ID_EX_PERF_CNT_EN
      check("bubble_cnt", bubble_cnt_o, cnt_model);
`endif
    end
  end

  // Apply inputs, let one rising edge pass, return at the following falling edge.
  task automatic drive(input logic rst, input logic vld, input logic [31:0] ins,
                       input logic [31:0] pc, input logic stl, input logic fls);
    rst_n = rst;
    instr_valid_i = vld;
    instr_i = ins;
    pc_i = pc;
    stall_i = stl;
    flush_i = fls;
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(1'b0, 1'b1, 32'h002081B3, 32'h40, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_op", 32'(ex_alu_op_o), 32'(ALU_NOP));
    check("rst_imm", ex_imm_o, 32'h0);

    drive(1'b1, 1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
    check("add_op", 32'(ex_alu_op_o), 32'(ALU_ADD));
    check("add_rs1", 32'(ex_rs1_o), 32'd1);
    check("add_rs2", 32'(ex_rs2_o), 32'd2);
    check("add_rd", 32'(ex_rd_o), 32'd3);
    check("add_srcb", 32'(ex_src_b_imm_o), 32'd0);
    check("add_we", 32'(ex_reg_write_o), 32'd1);
    check("add_pc", ex_pc_o, 32'h100);
    drive(1'b1, 1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b0);
    check("sub_op", 32'(ex_alu_op_o), 32'(ALU_SUB));
    drive(1'b1, 1'b1, 32'h40435293, 32'h108, 1'b0, 1'b0);
    check("srai_op", 32'(ex_alu_op_o), 32'(ALU_SRA));
    check("srai_imm", ex_imm_o, 32'h4);
    check("srai_srcb", 32'(ex_src_b_imm_o), 32'd1);
    drive(1'b1, 1'b1, 32'hABCDE3B7, 32'h10C, 1'b0, 1'b0);
    check("lui_op", 32'(ex_alu_op_o), 32'(ALU_LUI));
    check("lui_imm", ex_imm_o, 32'hABCDE000);
    drive(1'b1, 1'b1, 32'hFFF00093, 32'h110, 1'b0, 1'b0);
    check("addi_m1_imm", ex_imm_o, 32'hFFFFFFFF);

    drive(1'b1, 1'b1, 32'h002081B3, 32'h114, 1'b0, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    cnt_snap = bubble_cnt_o;
`endif
    drive(1'b1, 1'b1, 32'h402081B3, 32'h118, 1'b1, 1'b0);
    check("stall_hold_op", 32'(ex_alu_op_o), 32'(ALU_ADD));
    check("stall_hold_pc", ex_pc_o, 32'h114);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_stall_hold", bubble_cnt_o, cnt_snap);
`endif
    drive(1'b1, 1'b1, 32'h402081B3, 32'h118, 1'b1, 1'b1);
    check("flush_valid", 32'(ex_valid_o), 32'd0);
    check("flush_op", 32'(ex_alu_op_o), 32'(ALU_NOP));
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_flush_inc", bubble_cnt_o, cnt_snap + 32'd1);
    drive(1'b1, 1'b1, 32'h402081B3, 32'h118, 1'b1, 1'b0);
    check("cnt_stall_only", bubble_cnt_o, cnt_snap + 32'd1);
`endif

    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h11C, 1'b0, 1'b0);
    check("ill_flag", 32'(ex_illegal_o), 32'd1);
    check("ill_op", 32'(ex_alu_op_o), 32'(ALU_NOP));
    check("ill_we", 32'(ex_reg_write_o), 32'd0);
    check("ill_valid", 32'(ex_valid_o), 32'd1);
    drive(1'b1, 1'b1, 32'h00100013, 32'h120, 1'b0, 1'b0);
    check("x0_we", 32'(ex_reg_write_o), 32'd0);
    check("x0_op", 32'(ex_alu_op_o), 32'(ALU_ADD));

    drive(1'b1, 1'b1, 32'h402081B3, 32'h124, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h402081B3, 32'h128, 1'b1, 1'b0);
    check("midrst_valid", 32'(ex_valid_o), 32'd0);
    check("midrst_op", 32'(ex_alu_op_o), 32'(ALU_NOP));
    check("midrst_rd", 32'(ex_rd_o), 32'd0);
    check("midrst_pc", ex_pc_o, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        ins[6:0] = opc_tbl[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h20;
          default: ;
        endcase
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      end
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0, ins,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
